data_bus_arbiter: RTL and testbench

//  Shares the single data-memory port (64KB space, RAM window 0x40..0xBF) between two requesters:

---
 rtl/data_bus_arbiter_if.sv | 50 +++++
 rtl/data_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter_if
// Bundles the two requester ports, the shared response channel and the RAM
// port of data_bus_arbiter.
//   req_valid/req_we      [1:0]  per-port request valid / write enable
//   req0_addr/req1_addr          per-port address
//   req0_wdata/req1_wdata        per-port write data
//   req_ready             [1:0]  one-hot accept (combinational)
//   resp_done             [1:0]  one-hot single-cycle completion pulse
//   resp_rdata/resp_err          response data / out-of-window flag
//   mem_addr/mem_wdata           RAM address / write data
//   mem_rdata                    RAM read data
//   mem_cs/mem_we/mem_oe         RAM strobes
// Modports: slave = the arbiter, master = requesters plus RAM.
// -----------------------------------------------------------------------------
interface data_bus_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [1:0]            req_valid;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [1:0]            req_ready;
    logic [1:0]            resp_done;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;

    modport slave (
        input  req_valid, req_we, req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  mem_rdata,
        output req_ready, resp_done, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
    );

    modport master (
        output req_valid, req_we, req0_addr, req1_addr, req0_wdata, req1_wdata,
        output mem_rdata,
        input  req_ready, resp_done, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
// Shares one data-memory port between port 0 (control-unit bus interface) and
// port 1 (debug/DMA master). One request is accepted at a time in IDLE; an
// in-window request runs WAIT_STATES+1 RAM cycles, an out-of-window request
// answers with an error straight away without touching the RAM.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    data_bus_arbiter_if.slave (requests, response, RAM port)
//   busy   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int             DATA_WIDTH     = 8,
    parameter int             ADDR_WIDTH     = 16,
    parameter logic [7:0]     MEM_START_ADDR = 8'h40,
    parameter logic [7:0]     MEM_STOP_ADDR  = 8'hBF,
    parameter int             WAIT_STATES    = 1,
    parameter bit             PRIORITY_MODE  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    data_bus_arbiter_if.slave   bus,
    output logic                busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  last_grant;
    logic                  port_q;
    logic                  we_q;
    logic [3:0]            wait_cnt;

    // Arbitration / decode of the candidate request
    logic                  winner;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_we;
    logic                  win_in_window;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        winner = 1'b0;
        unique case (bus.req_valid)
            2'b10:   winner = 1'b1;
            // Tie: fixed mode always favours port 0; round-robin picks the
            // port that did not win last time.
            2'b11:   winner = PRIORITY_MODE ? 1'b0 : ~last_grant;
            default: winner = 1'b0;
        endcase

        accept        = (state == IDLE) && (bus.req_valid != 2'b00);
        win_addr      = winner ? bus.req1_addr  : bus.req0_addr;
        win_wdata     = winner ? bus.req1_wdata : bus.req0_wdata;
        win_we        = bus.req_we[winner];
        win_in_window = (win_addr[ADDR_WIDTH-1:8] == '0)
                     && (win_addr[7:0] >= MEM_START_ADDR)
                     && (win_addr[7:0] <= MEM_STOP_ADDR);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register in the design
        // samples pre-edge values regardless of process evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and strobes
    always_comb begin
        state_next    = state;
        bus.req_ready = 2'b00;
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_oe    = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    bus.req_ready = winner ? 2'b10 : 2'b01;
                    state_next    = win_in_window ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                bus.mem_cs = 1'b1;
                bus.mem_we = we_q;
                bus.mem_oe = ~we_q;
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: request latch, wait counter, RAM bus registers, response
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant     <= 1'b1;
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            wait_cnt       <= 4'd0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_done  <= 2'b00;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            // Response fields are single-cycle; they are only loaded on the
            // edge that enters RESP.
            bus.resp_done  <= 2'b00;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= winner;
                        port_q     <= winner;
                        we_q       <= win_we;
                        wait_cnt   <= WAIT_LOAD;
                        if (win_in_window) begin
                            // RAM address/data only move for real accesses,
                            // so the RAM bus holds its last value otherwise.
                            bus.mem_addr <= win_addr;
                            if (win_we) begin
                                bus.mem_wdata <= win_wdata;
                            end
                        end else begin
                            bus.resp_done <= winner ? 2'b10 : 2'b01;
                            bus.resp_err  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        bus.resp_done  <= port_q ? 2'b10 : 2'b01;
                        bus.resp_rdata <= we_q ? '0 : bus.mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
// Testbench for data_bus_arbiter. Two instances: dut_a (round-robin,
// WAIT_STATES=2) and dut_b (fixed priority, WAIT_STATES=1), each with its own
// small RAM model. Expected responses are queued when a request is accepted
// and compared by a per-instance monitor when resp_done fires.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

    localparam int WS_A = 2;
    localparam int WS_B = 1;

    typedef struct {
        logic [1:0] done;
        logic [7:0] rdata;
        logic       err;
    } resp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic busy_a;
    logic busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    resp_t exp_a[$];
    resp_t exp_b[$];
    resp_t mon_a_item;
    resp_t mon_b_item;

    logic [15:0] last_addr_a = 16'h0000;

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) if_a ();
    data_bus_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) if_b ();

    data_bus_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_START_ADDR(8'h40), .MEM_STOP_ADDR(8'hBF),
        .WAIT_STATES(WS_A), .PRIORITY_MODE(1'b0)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(if_a.slave), .busy(busy_a)
    );

    data_bus_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_START_ADDR(8'h40), .MEM_STOP_ADDR(8'hBF),
        .WAIT_STATES(WS_B), .PRIORITY_MODE(1'b1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(if_b.slave), .busy(busy_b)
    );

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // RAM models: preset pattern (0x50 holds 0xA5), writes on cs & we.
    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    bit ram_a_loaded = 1'b0;
    bit ram_b_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_a_loaded) begin
            for (int i = 0; i < 256; i++) ram_a[i] <= pat(8'(i));
            ram_a[8'h50] <= 8'hA5;
            ram_a_loaded <= 1'b1;
        end else if (if_a.mem_cs && if_a.mem_we) begin
            ram_a[if_a.mem_addr[7:0]] <= if_a.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (!ram_b_loaded) begin
            for (int i = 0; i < 256; i++) ram_b[i] <= pat(8'(i));
            ram_b_loaded <= 1'b1;
        end else if (if_b.mem_cs && if_b.mem_we) begin
            ram_b[if_b.mem_addr[7:0]] <= if_b.mem_wdata;
        end
    end

    assign if_a.mem_rdata = ram_a[if_a.mem_addr[7:0]];
    assign if_b.mem_rdata = ram_b[if_b.mem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        #2;
        if (if_a.resp_done != 2'b00) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_done", 32'(if_a.resp_done), 32'h0);
            end else begin
                mon_a_item = exp_a.pop_front();
                check("a_sb_done",  32'(if_a.resp_done),  32'(mon_a_item.done));
                check("a_sb_rdata", 32'(if_a.resp_rdata), 32'(mon_a_item.rdata));
                check("a_sb_err",   32'(if_a.resp_err),   32'(mon_a_item.err));
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (if_b.resp_done != 2'b00) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_done", 32'(if_b.resp_done), 32'h0);
            end else begin
                mon_b_item = exp_b.pop_front();
                check("b_sb_done",  32'(if_b.resp_done),  32'(mon_b_item.done));
                check("b_sb_rdata", 32'(if_b.resp_rdata), 32'(mon_b_item.rdata));
                check("b_sb_err",   32'(if_b.resp_err),   32'(mon_b_item.err));
            end
        end
    end

    // Single request on dut_a, checked cycle by cycle until resp_done.
    task automatic run_a(input string tag, input bit port, input bit we, input logic [15:0] addr,
                         input logic [7:0] wdata, input bit in_win, input logic [7:0] exp_rdata);
        int         lat;
        logic [1:0] oh;
        logic [15:0] exp_maddr;
        oh = port ? 2'b10 : 2'b01;
        @(negedge clk);
        if_a.req_we = port ? {we, 1'b0} : {1'b0, we};
        if (port) begin
            if_a.req1_addr  = addr;
            if_a.req1_wdata = wdata;
        end else begin
            if_a.req0_addr  = addr;
            if_a.req0_wdata = wdata;
        end
        if_a.req_valid = oh;
        #1;
        check({tag, "_ready"}, 32'(if_a.req_ready), 32'(oh));
        check({tag, "_cs_idle"}, 32'(if_a.mem_cs), 32'h0);
        exp_a.push_back('{oh, in_win ? exp_rdata : 8'h00, !in_win});
        if (in_win) last_addr_a = addr;
        exp_maddr = last_addr_a;
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                check({tag, "_ready_busy"}, 32'(if_a.req_ready), 32'h0);
                if_a.req_valid = 2'b00;
            end
            if (if_a.resp_done == 2'b00) begin
                check({tag, "_acc_cs"},   32'(if_a.mem_cs),   32'(in_win));
                check({tag, "_acc_we"},   32'(if_a.mem_we),   32'(in_win && we));
                check({tag, "_acc_oe"},   32'(if_a.mem_oe),   32'(in_win && !we));
                check({tag, "_acc_addr"}, 32'(if_a.mem_addr), 32'(addr));
                if (we) check({tag, "_acc_wdata"}, 32'(if_a.mem_wdata), 32'(wdata));
            end
        end while (if_a.resp_done == 2'b00 && lat < 40);
        check({tag, "_latency"}, 32'(lat), in_win ? 32'(WS_A + 2) : 32'h1);
        check({tag, "_resp_cs"}, 32'(if_a.mem_cs), 32'h0);
        check({tag, "_resp_busy"}, 32'(busy_a), 32'h1);
        check({tag, "_resp_maddr"}, 32'(if_a.mem_addr), 32'(exp_maddr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  cyc;
        int  last_acc;
        bit  rr_last;
        bit  winner;
        int  n;
        logic [15:0] t5_addr [6];
        bit          t5_win  [6];

        if_a.req_valid = 2'b00; if_a.req_we = 2'b00;
        if_a.req0_addr = '0; if_a.req1_addr = '0; if_a.req0_wdata = '0; if_a.req1_wdata = '0;
        if_b.req_valid = 2'b00; if_b.req_we = 2'b00;
        if_b.req0_addr = '0; if_b.req1_addr = '0; if_b.req0_wdata = '0; if_b.req1_wdata = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        #1;

        // Reset state
        check("rst_a_busy",  32'(busy_a), 32'h0);
        check("rst_a_done",  32'(if_a.resp_done), 32'h0);
        check("rst_a_rdata", 32'(if_a.resp_rdata), 32'h0);
        check("rst_a_err",   32'(if_a.resp_err), 32'h0);
        check("rst_a_strb",  32'({if_a.mem_cs, if_a.mem_we, if_a.mem_oe}), 32'h0);
        check("rst_a_ready", 32'(if_a.req_ready), 32'h0);
        check("rst_b_busy",  32'(busy_b), 32'h0);
        check("rst_b_strb",  32'({if_b.mem_cs, if_b.mem_we, if_b.mem_oe}), 32'h0);

        // 1: port 0 read 0x0050, WAIT_STATES=2
        @(negedge clk);
        if_a.req_we = 2'b00; if_a.req0_addr = 16'h0050; if_a.req_valid = 2'b01;
        #1;
        check("t1_ready", 32'(if_a.req_ready), 32'h1);
        exp_a.push_back('{2'b01, 8'hA5, 1'b0});
        last_addr_a = 16'h0050;
        for (int c = 1; c <= WS_A + 1; c++) begin
            @(negedge clk);
            #1;
            check("t1_ready_busy", 32'(if_a.req_ready), 32'h0);
            if_a.req_valid = 2'b00;
            check("t1_cs",   32'(if_a.mem_cs), 32'h1);
            check("t1_oe",   32'(if_a.mem_oe), 32'h1);
            check("t1_we",   32'(if_a.mem_we), 32'h0);
            check("t1_addr", 32'(if_a.mem_addr), 32'h0050);
            check("t1_done_early", 32'(if_a.resp_done), 32'h0);
        end
        @(negedge clk);
        #1;
        check("t1_done",  32'(if_a.resp_done), 32'h1);
        check("t1_rdata", 32'(if_a.resp_rdata), 32'hA5);
        check("t1_err",   32'(if_a.resp_err), 32'h0);
        check("t1_cs_resp", 32'(if_a.mem_cs), 32'h0);
        @(negedge clk);
        #1;
        check("t1_done_once", 32'(if_a.resp_done), 32'h0);
        check("t1_idle",      32'(busy_a), 32'h0);

        // 2: round-robin from reset, both ports valid continuously
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        if_a.req_we = 2'b00; if_a.req0_addr = 16'h0060; if_a.req1_addr = 16'h0070;
        if_a.req_valid = 2'b11;
        #1;
        cyc = 0; last_acc = 0; rr_last = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (if_a.req_ready == 2'b00 && n < 40) begin
                @(negedge clk);
                #1;
                cyc++;
                n++;
            end
            winner = !rr_last;
            check("t2_grant", 32'(if_a.req_ready), winner ? 32'h2 : 32'h1);
            if (g > 0) check("t2_gap", 32'(cyc - last_acc), 32'(WS_A + 3));
            last_acc = cyc;
            rr_last  = winner;
            exp_a.push_back('{winner ? 2'b10 : 2'b01, pat(winner ? 8'h70 : 8'h60), 1'b0});
            last_addr_a = winner ? 16'h0070 : 16'h0060;
            @(negedge clk);
            #1;
            cyc++;
        end
        if_a.req_valid = 2'b00;
        repeat (WS_A + 3) @(negedge clk);

        // 3: fixed priority, both valid continuously, then port 0 drops
        @(negedge clk);
        if_b.req_we = 2'b00; if_b.req0_addr = 16'h0041; if_b.req1_addr = 16'h0042;
        if_b.req_valid = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (if_b.req_ready == 2'b00 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
            // The last grant is taken after port 0 has withdrawn.
            check("t3_grant", 32'(if_b.req_ready), (g == 3) ? 32'h2 : 32'h1);
            exp_b.push_back('{(g == 3) ? 2'b10 : 2'b01, pat((g == 3) ? 8'h42 : 8'h41), 1'b0});
            @(negedge clk);
            #1;
            if (g == 2) if_b.req_valid = 2'b10;
            if (g == 3) if_b.req_valid = 2'b00;
        end

        // 4: port 1 write 0x00BF, then read it back through port 0
        run_a("t4_wr", 1'b1, 1'b1, 16'h00BF, 8'h3C, 1'b1, 8'h00);
        run_a("t4_rd", 1'b0, 1'b0, 16'h00BF, 8'h00, 1'b1, 8'h3C);

        // 5: window boundaries and out-of-window errors
        t5_addr = '{16'h0020, 16'h0140, 16'h003F, 16'h00C0, 16'h0040, 16'hFF50};
        t5_win  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            run_a("t5", 1'b0, 1'b0, t5_addr[k], 8'h00, t5_win[k], pat(t5_addr[k][7:0]));
        end

        // 6: reset during the second ACCESS cycle
        @(negedge clk);
        if_a.req_we = 2'b00; if_a.req0_addr = 16'h0055; if_a.req_valid = 2'b01;
        #1;
        check("t6_ready", 32'(if_a.req_ready), 32'h1);
        @(negedge clk);
        #1;
        if_a.req_valid = 2'b00;
        check("t6_cs1", 32'(if_a.mem_cs), 32'h1);
        @(negedge clk);
        #1;
        check("t6_cs2", 32'(if_a.mem_cs), 32'h1);
        rst_a = 1'b1;
        @(negedge clk);
        #1;
        check("t6_rst_strb", 32'({if_a.mem_cs, if_a.mem_we, if_a.mem_oe}), 32'h0);
        check("t6_rst_busy", 32'(busy_a), 32'h0);
        check("t6_rst_done", 32'(if_a.resp_done), 32'h0);
        rst_a = 1'b0;
        last_addr_a = 16'h0055;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("t6_no_done", 32'(if_a.resp_done), 32'h0);
            check("t6_idle",    32'(busy_a), 32'h0);
        end
        run_a("t6_after", 1'b0, 1'b0, 16'h0056, 8'h00, 1'b1, pat(8'h56));

        repeat (6) @(negedge clk);
        check("a_sb_drained", 32'(exp_a.size()), 32'h0);
        check("b_sb_drained", 32'(exp_b.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
